mux_nxw_skid: RTL and testbench

- Parametrised successor to the 2:1 32-bit datapath select: NUM_IN-way, WIDTH-bit select, registered through a 2-entry valid/ready skid buffer.
- Lets the core pipeline (operand select, writeback select, PC-source select) cut timing at the select point without losing data under back-pressure.
- Sits between a producing pipeline stage and a consuming stage, with stall and flush support.

---
 rtl/mux_pkg.sv | 31 +++
 rtl/mux_nxw_comb.sv | 52 +++++
 rtl/mux_nxw_skid.sv | 168 ++++++++++++++++
 tb/tb_mux_nxw_skid.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types and helpers for the NUM_IN:1 WIDTH-bit select
//             with skid buffer (state encoding, select-width helper,
//             zero-fill value used for out-of-range selects).
//  Ports    : none (package)
//  Options  : MUX_NXW_SEL_CHECK_EN (used by mux_nxw_skid, not here)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // no entries held
    ST_ONE   = 2'd1,   // main register holds the head entry
    ST_TWO   = 2'd2    // main + skid both hold entries
  } skid_state_t;

  // Select width for an N-way mux; a 1-way mux still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit replicated to form the data value of an out-of-range select.
  localparam logic ZERO_FILL_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mux_nxw_comb.sv
// ============================================================================
//  Module   : mux_nxw_comb
//  Purpose  : Pure combinational NUM_IN:1 WIDTH-bit selector. Selects
//             d[s*WIDTH +: WIDTH]; a select at or above NUM_IN yields zero
//             data and raises sel_err.
//  Ports    : d       in  NUM_IN*WIDTH  flattened inputs
//             s       in  SEL_W         select
//             y       out WIDTH         selected data (zero when out of range)
//             sel_err out 1             select is out of range
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nxw_comb
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        s,
  output logic [WIDTH-1:0]        y,
  output logic                    sel_err
);

  logic [WIDTH-1:0] lanes [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign lanes[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Compare against each legal index rather than indexing lanes[s], so an
  // out-of-range select never reads past the array and falls to zero-fill.
  always_comb begin
    y = {WIDTH{ZERO_FILL_BIT}};
    for (int i = 0; i < NUM_IN; i++) begin
      if (s == SEL_W'(i)) begin
        y = lanes[i];
      end
    end
  end

  // Extra bit so NUM_IN itself is representable when NUM_IN is a power of 2.
  assign sel_err = ({1'b0, s} >= (SEL_W + 1)'(NUM_IN));

endmodule

`default_nettype wire

// File: rtl/mux_nxw_skid.sv
// ============================================================================
//  Module   : mux_nxw_skid
//  Purpose  : NUM_IN:1 WIDTH-bit select registered through a 2-entry
//             valid/ready skid buffer with flush. Strict FIFO order,
//             1-cycle latency from an accepted input when empty.
//  Ports    : CLK       in  1             clock, rising edge
//             RST       in  1             async active-high reset
//             D         in  NUM_IN*WIDTH  flattened data inputs
//             S         in  SEL_W         select, sampled on input handshake
//             IN_VALID  in  1             producer has D/S valid
//             IN_READY  out 1             block can accept (registered)
//             FLUSH     in  1             synchronous discard of all entries
//             Y         out WIDTH         head entry data (registered)
//             OUT_VALID out 1             Y holds a valid entry
//             OUT_READY in  1             consumer accepts Y
//             SEL_ERR   out 1             head entry had out-of-range select
//  Options  : MUX_NXW_SEL_CHECK_EN - store the out-of-range flag with each
//             entry, drive SEL_ERR from it, and assert on out-of-range S at
//             input handshake. Undefined: SEL_ERR is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nxw_skid
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_IN*WIDTH-1:0] D,
  input  logic [SEL_W-1:0]        S,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    FLUSH,
  output logic [WIDTH-1:0]        Y,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    SEL_ERR
);

  skid_state_t      state_q, state_n;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;

  logic [WIDTH-1:0] mux_y;
  logic             mux_oor;

  logic accept;
  logic pop;
  logic ld_main_mux;
  logic ld_main_skid;
  logic ld_skid;

  mux_nxw_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .d       (D),
    .s       (S),
    .y       (mux_y),
    .sel_err (mux_oor)
  );

  assign accept = IN_VALID && in_ready_q;
  assign pop    = OUT_VALID && OUT_READY;

  always_comb begin
    state_n      = state_q;
    ld_main_mux  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (FLUSH) begin
      // Anything accepted this cycle is dropped along with the buffer.
      state_n = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_n     = ST_ONE;
            ld_main_mux = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            ld_main_mux = 1'b1;
          end else if (accept) begin
            state_n = ST_TWO;
            ld_skid = 1'b1;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_q is low here, so no accept can occur.
          if (pop) begin
            state_n      = ST_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      // Ready is registered from the next state, keeping OUT_READY off any
      // combinational path to IN_READY.
      in_ready_q <= (state_n != ST_TWO);
      if (ld_main_mux) begin
        main_q <= mux_y;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= mux_y;
      end
    end
  end

  assign Y         = main_q;
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign IN_READY  = in_ready_q;

`ifdef MUX_NXW_SEL_CHECK_EN
  logic err_main_q;
  logic err_skid_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_main_q <= 1'b0;
      err_skid_q <= 1'b0;
    end else begin
      if (ld_main_mux) begin
        err_main_q <= mux_oor;
      end else if (ld_main_skid) begin
        err_main_q <= err_skid_q;
      end
      if (ld_skid) begin
        err_skid_q <= mux_oor;
      end
    end
  end

  assign SEL_ERR = OUT_VALID && err_main_q;

  a_sel_in_range: assert property (@(posedge CLK) disable iff (RST)
                                   !(accept && mux_oor));
`else
  logic unused_oor;
  assign unused_oor = mux_oor;
  assign SEL_ERR    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nxw_skid.sv
// ============================================================================
//  Module   : tb_mux_nxw_skid
//  Purpose  : Directed self-checking bench for mux_nxw_skid. Instance a is
//             NUM_IN=4, instance b is NUM_IN=3 (exercises out-of-range S).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nxw_skid;

  logic clk;
  logic rst;

  // Instance a: NUM_IN=4, WIDTH=32
  logic [127:0] d_a;
  logic [1:0]   s_a;
  logic         in_valid_a, in_ready_a, flush_a;
  logic [31:0]  y_a;
  logic         out_valid_a, out_ready_a, sel_err_a;

  // Instance b: NUM_IN=3, WIDTH=32
  logic [95:0]  d_b;
  logic [1:0]   s_b;
  logic         in_valid_b, in_ready_b, flush_b;
  logic [31:0]  y_b;
  logic         out_valid_b, out_ready_b, sel_err_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] lane_val [4];
  logic        exp_oor_err;

  mux_nxw_skid #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .CLK       (clk),
    .RST       (rst),
    .D         (d_a),
    .S         (s_a),
    .IN_VALID  (in_valid_a),
    .IN_READY  (in_ready_a),
    .FLUSH     (flush_a),
    .Y         (y_a),
    .OUT_VALID (out_valid_a),
    .OUT_READY (out_ready_a),
    .SEL_ERR   (sel_err_a)
  );

  mux_nxw_skid #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .CLK       (clk),
    .RST       (rst),
    .D         (d_b),
    .S         (s_b),
    .IN_VALID  (in_valid_b),
    .IN_READY  (in_ready_b),
    .FLUSH     (flush_b),
    .Y         (y_b),
    .OUT_VALID (out_valid_b),
    .OUT_READY (out_ready_b),
    .SEL_ERR   (sel_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    lane_val[0] = 32'h11;
    lane_val[1] = 32'h22;
    lane_val[2] = 32'h33;
    lane_val[3] = 32'h44;
`ifdef MUX_NXW_SEL_CHECK_EN
    exp_oor_err = 1'b1;
`else
    exp_oor_err = 1'b0;
`endif

    rst         = 1'b1;
    d_a         = {32'h44, 32'h33, 32'h22, 32'h11};
    s_a         = 2'd0;
    in_valid_a  = 1'b0;
    flush_a     = 1'b0;
    out_ready_a = 1'b0;
    d_b         = {32'h33, 32'h22, 32'h11};
    s_b         = 2'd0;
    in_valid_b  = 1'b0;
    flush_b     = 1'b0;
    out_ready_b = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check_val("rst_y",         y_a,         32'h0);
    check_val("rst_out_valid", out_valid_a, 32'h0);
    check_val("rst_in_ready",  in_ready_a,  32'h1);
    check_val("rst_sel_err",   sel_err_a,   32'h0);
    rst = 1'b0;

    // ---- basic: S=2 -> 0x33 one cycle later ----
    @(negedge clk);
    s_a = 2'd2; in_valid_a = 1'b1; out_ready_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    check_val("basic_y",         y_a,         32'h33);
    check_val("basic_out_valid", out_valid_a, 32'h1);
    check_val("basic_in_ready",  in_ready_a,  32'h1);
    @(negedge clk);
    check_val("basic_drained", out_valid_a, 32'h0);

    // ---- back-pressure: push S=0 then S=3 with OUT_READY low ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; s_a = 2'd0;
    @(negedge clk);
    check_val("bp_y_first",    y_a,        32'h11);
    check_val("bp_ready_one",  in_ready_a, 32'h1);
    s_a = 2'd3;
    @(negedge clk);
    in_valid_a = 1'b0;
    check_val("bp_y_hold",     y_a,        32'h11);
    check_val("bp_ready_two",  in_ready_a, 32'h0);
    @(negedge clk);
    check_val("bp_y_stable",   y_a,        32'h11);
    check_val("bp_ov_stable",  out_valid_a, 32'h1);
    out_ready_a = 1'b1;
    @(negedge clk);
    check_val("bp_y_second",   y_a,        32'h44);
    check_val("bp_ready_pop",  in_ready_a, 32'h1);
    @(negedge clk);
    check_val("bp_drained",    out_valid_a, 32'h0);

    // ---- streaming: S cycles 0..3 for 8 cycles, no bubbles ----
    in_valid_a = 1'b1; out_ready_a = 1'b1; s_a = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("stream_y_%0d", i), y_a, lane_val[i % 4]);
      check_val($sformatf("stream_ov_%0d", i), out_valid_a, 32'h1);
      check_val($sformatf("stream_rdy_%0d", i), in_ready_a, 32'h1);
      s_a = 2'((i + 1) % 4);
    end
    in_valid_a = 1'b0;
    @(negedge clk);
    check_val("stream_drained", out_valid_a, 32'h0);

    // ---- out-of-range select on NUM_IN=3 instance ----
    s_b = 2'd2; in_valid_b = 1'b1; out_ready_b = 1'b1;
    @(negedge clk);
    check_val("oor_inrange_y",   y_b,       32'h33);
    check_val("oor_inrange_err", sel_err_b, 32'h0);
    s_b = 2'd3;
    @(negedge clk);
    in_valid_b = 1'b0;
    check_val("oor_y",         y_b,         32'h0);
    check_val("oor_out_valid", out_valid_b, 32'h1);
    check_val("oor_sel_err",   sel_err_b,   32'(exp_oor_err));
    @(negedge clk);
    check_val("oor_drained", out_valid_b, 32'h0);

    // ---- flush from TWO with IN_VALID high ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; s_a = 2'd1;
    @(negedge clk);
    s_a = 2'd2;
    @(negedge clk);
    check_val("flush_pre_ready", in_ready_a, 32'h0);
    flush_a = 1'b1; s_a = 2'd3;
    @(negedge clk);
    flush_a = 1'b0; in_valid_a = 1'b0;
    check_val("flush_out_valid", out_valid_a, 32'h0);
    check_val("flush_in_ready",  in_ready_a,  32'h1);
    out_ready_a = 1'b1;
    repeat (2) @(negedge clk);
    check_val("flush_no_ghost", out_valid_a, 32'h0);

    // ---- flush from ONE while a handshake happens: input discarded ----
    out_ready_a = 1'b0; in_valid_a = 1'b1; s_a = 2'd0;
    @(negedge clk);
    flush_a = 1'b1; s_a = 2'd3;
    @(negedge clk);
    flush_a = 1'b0; in_valid_a = 1'b0;
    check_val("flush1_out_valid", out_valid_a, 32'h0);
    check_val("flush1_in_ready",  in_ready_a,  32'h1);
    out_ready_a = 1'b1; in_valid_a = 1'b1; s_a = 2'd1;
    @(negedge clk);
    in_valid_a = 1'b0;
    check_val("flush1_recover_y", y_a, 32'h22);

    // ---- async reset mid-transfer while in TWO ----
    @(negedge clk);
    out_ready_a = 1'b0; in_valid_a = 1'b1; s_a = 2'd0;
    @(negedge clk);
    s_a = 2'd1;
    @(negedge clk);
    in_valid_a = 1'b0;
    check_val("arst_pre_ready", in_ready_a, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_y",         y_a,         32'h0);
    check_val("arst_out_valid", out_valid_a, 32'h0);
    check_val("arst_in_ready",  in_ready_a,  32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_after", out_valid_a, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
